// File: rtl/dected_pkg.sv
// Shared types for the DECTED load stage: error classes and the error-log entry.
package dected_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CE   = 2'b01;
  localparam logic [1:0] ERR_UE   = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  err_type;
  } log_entry_t;

  // An uncorrectable error dominates: a triple error is never reported as CE.
  function automatic logic [1:0] classify_err(input logic sde, input logic te);
    if (te)       return ERR_UE;
    else if (sde) return ERR_CE;
    else          return ERR_NONE;
  endfunction

endpackage

// File: rtl/dected_load_stage_if.sv
// Load-word handshake from the correction logic and response handshake to the core.
interface dected_load_stage_if;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] corrected_data;
  logic        single_double_error;
  logic        triple_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  modport master (
    output ld_valid, ld_addr, corrected_data, single_double_error, triple_error, rsp_ready,
    input  ld_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  ld_valid, ld_addr, corrected_data, single_double_error, triple_error, rsp_ready,
    output ld_ready, rsp_valid, rsp_data, rsp_fault
  );

endinterface

// File: rtl/dected_err_log_fifo.sv
// Synchronous error-address log FIFO with push, pop and flush; wrap-bit pointers.
// Also tracks how many UE entries are held so the parent can raise irq.
module dected_err_log_fifo
  import dected_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  log_entry_t push_entry,
  input  logic       pop,
  input  logic       flush,
  output logic       empty,
  output logic       full,
  output logic       ue_present,
  output log_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] ue_cnt_q, ue_cnt_d;
  log_entry_t  mem_q [DEPTH];
  log_entry_t  head_raw;
  logic        push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_raw = mem_q[rd_ptr_q[AW-1:0]];
  assign head     = empty ? '0 : head_raw;
  assign pop_ok   = pop && !empty;
  // A full FIFO still takes a push when a pop frees the head slot on the same edge.
  assign push_ok  = push && (!full || pop_ok);
  assign ue_present = (ue_cnt_q != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ue_cnt_d = ue_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ue_cnt_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      ue_cnt_d = ue_cnt_q
               + (AW+1)'(push_ok && (push_entry.err_type == ERR_UE))
               - (AW+1)'(pop_ok  && (head_raw.err_type   == ERR_UE));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/dected_load_stage.sv
// Registered consumer stage after DECTED load correction: response register, error counters, irq.
// Define DECTED_ERR_LOG_EN to include the error-address log FIFO; otherwise irq is a sticky UE flag.
module dected_load_stage
  import dected_pkg::*;
#(
  parameter int LOG_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dected_load_stage_if.slave   bus,
  output logic [CNT_W-1:0]     ce_count,
  output logic [CNT_W-1:0]     ue_count,
  input  logic                 err_clr,
  input  logic                 log_pop,
  output logic                 log_empty,
  output logic [31:0]          log_addr,
  output logic [1:0]           log_type,
  output logic                 log_overflow,
  output logic                 irq
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q,  rsp_data_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [CNT_W-1:0] ce_count_q,  ce_count_d;
  logic [CNT_W-1:0] ue_count_q,  ue_count_d;
  logic             accept, is_ce, is_ue;
  logic [1:0]       err_type;

  // Single output register: refill on the same edge the held word is consumed.
  assign bus.ld_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept       = bus.ld_valid && bus.ld_ready;
  assign err_type     = classify_err(bus.single_double_error, bus.triple_error);
  assign is_ce        = accept && (err_type == ERR_CE);
  assign is_ue        = accept && (err_type == ERR_UE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign ce_count      = ce_count_q;
  assign ue_count      = ue_count_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.corrected_data;
      rsp_fault_d = bus.triple_error;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    ce_count_d = ce_count_q;
    ue_count_d = ue_count_q;
    if (err_clr) begin
      ce_count_d = '0;
      ue_count_d = '0;
    end else begin
      if (is_ce && (ce_count_q != {CNT_W{1'b1}})) ce_count_d = ce_count_q + CNT_W'(1);
      if (is_ue && (ue_count_q != {CNT_W{1'b1}})) ue_count_d = ue_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      ce_count_q  <= '0;
      ue_count_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      ce_count_q  <= ce_count_d;
      ue_count_q  <= ue_count_d;
    end
  end

`ifdef DECTED_ERR_LOG_EN
  log_entry_t push_entry, head;
  logic       log_push, fifo_full, ue_present;
  logic       overflow_q, overflow_d;

  assign log_push   = is_ce || is_ue;
  assign push_entry = '{addr: bus.ld_addr, err_type: err_type};

  dected_err_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .rst        (rst),
    .push       (log_push),
    .push_entry (push_entry),
    .pop        (log_pop),
    .flush      (err_clr),
    .empty      (log_empty),
    .full       (fifo_full),
    .ue_present (ue_present),
    .head       (head)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (err_clr)                                   overflow_d = 1'b0;
    else if (log_push && fifo_full && !log_pop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign log_addr     = head.addr;
  assign log_type     = head.err_type;
  assign log_overflow = overflow_q;
  assign irq          = ue_present || overflow_q;
`else
  logic        ue_flag_q, ue_flag_d;
  logic [32:0] unused_log_inputs;

  assign unused_log_inputs = {log_pop, bus.ld_addr};

  always_comb begin
    ue_flag_d = ue_flag_q;
    if (err_clr)    ue_flag_d = 1'b0;
    else if (is_ue) ue_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ue_flag_q <= 1'b0;
    else     ue_flag_q <= ue_flag_d;
  end

  assign log_empty    = 1'b1;
  assign log_addr     = '0;
  assign log_type     = ERR_NONE;
  assign log_overflow = 1'b0;
  assign irq          = ue_flag_q;
`endif

endmodule

// File: doc/dected_load_stage.md
# dected_load_stage

Registered consumer stage directly downstream of the DECTED load-correction logic. It captures the corrected 32-bit load word and its error flags under a valid/ready handshake, returns the word to the core, and tracks corrected and uncorrectable errors. Tracking uses saturating counters and an optional error-address log FIFO. It raises a level interrupt on uncorrectable (triple) errors and on log overflow.

## Interface
Parameters:
- LOG_DEPTH, 4: error-log FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the error counters.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- ld_valid  in  1  Corrected load word presented.
- ld_ready  out  1  Stage can accept the word this cycle.
- ld_addr  in  32  Load address of the word.
- corrected_data  in  32  Corrected word from the correction logic.
- single_double_error  in  1  A 1- or 2-bit error was corrected (CE).
- triple_error  in  1  A 3-bit error was detected and is uncorrectable (UE).
- rsp_valid  out  1  Response word held for the core.
- rsp_ready  in  1  Core accepts the response.
- rsp_data  out  32  Registered corrected_data.
- rsp_fault  out  1  Registered triple_error.
- ce_count  out  CNT_W  Corrected-error count, saturating.
- ue_count  out  CNT_W  Uncorrectable-error count, saturating.
- err_clr  in  1  Clears the counters, the overflow flag and the log.
- log_pop  in  1  Pop the log head.
- log_empty  out  1  Log holds no entries.
- log_addr  out  32  Address of the head entry.
- log_type  out  2  Type of the head entry: 01 = CE, 10 = UE.
- log_overflow  out  1  Sticky flag: an entry was dropped because the log was full.
- irq  out  1  Level interrupt.

## Operation
- Acceptance: a word is accepted when ld_valid && ld_ready.
- ld_ready = !rsp_valid || rsp_ready. This is a single output register with bubble-free throughput.
- On acceptance:
  - rsp_data ← corrected_data.
  - rsp_fault ← triple_error.
  - rsp_valid ← 1.
- Without a new acceptance, rsp_valid falls on rsp_valid && rsp_ready.
- Classification of an accepted word:
  - triple_error = 1 → UE. This holds even when single_double_error is also 1.
  - Otherwise single_double_error = 1 → CE.
  - Otherwise no error.
- Counters:
  - A CE increments ce_count; a UE increments ue_count.
  - Each counter holds at all-ones (saturates) and never wraps.
- Log:
  - Every CE or UE pushes {ld_addr, type}.
  - If the log is full and log_pop is not asserted in the same cycle, the entry is dropped and log_overflow is set.
  - Full with push and pop in the same cycle: both occur, so the count is unchanged.
  - log_pop while empty is ignored.
  - log_addr and log_type are 0 when the log is empty.
- err_clr:
  - Zeroes the counters, clears log_overflow and flushes the log.
  - It takes priority over any same-cycle increment or push; that event is lost.
  - It does not affect the response path.
- irq = (any UE entry present in log) || log_overflow.

## Timing
- Latency: 1 cycle. A word accepted at edge N gives rsp_valid high after edge N.
- Counter updates and log pushes take effect on the same edge as acceptance. log_empty falls the cycle after the push.
- Pop: the head advances on the edge where log_pop is sampled.
- Reset state:
  - rsp_valid, rsp_data, rsp_fault = 0.
  - Both counters = 0.
  - Log empty, so log_empty = 1 and log_addr, log_type = 0.
  - log_overflow = 0 and irq = 0.
- ld_ready is 1 in the cycle after reset.
- Reset mid-transfer discards the held response and the entire log with no partial state.
- Backpressure: while rsp_valid && !rsp_ready, ld_ready = 0 and the held response is stable.

## Configuration
- DECTED_ERR_LOG_EN defined: log FIFO, log_* outputs and log_overflow present as described.
- DECTED_ERR_LOG_EN undefined:
  - No FIFO is instantiated.
  - log_empty is tied to 1.
  - log_addr, log_type and log_overflow are tied to 0.
  - log_pop is ignored.
  - irq = sticky UE flag, set on any UE and cleared by err_clr or rst.
  - Counters and the response path are unchanged.

## Structure
- Shared package dected_pkg:
  - Error-type constants ERR_NONE = 2'b00, ERR_CE = 2'b01, ERR_UE = 2'b10.
  - The log-entry typedef {addr[31:0], type[1:0]}.
- Sub-module dected_err_log_fifo: synchronous FIFO with push, pop and flush.
  - Pointers are log2(LOG_DEPTH)+1 bits wide, using the wrap bit for full/empty.
  - It is instantiated only under DECTED_ERR_LOG_EN.

## Test plan
- Clean stream: addresses 0x100..0x10C, flags 0, rsp_ready = 1 → four responses, each 1 cycle after acceptance, with no bubbles; counters stay 0 and log_empty stays 1.
- CE then UE: CE at 0x200, then triple_error at 0x204 with single_double_error also 1 → ce_count = 1 and ue_count = 1. Pops return {0x200, 01} then {0x204, 10}. rsp_fault = 1 on the second response only. irq rises after the UE push and falls when that entry is popped.
- Backpressure: rsp_ready = 0 for 3 cycles with ld_valid held → ld_ready = 0 throughout, rsp_data stable; after release, the next word is accepted on the same edge the held one is consumed.
- Overflow: LOG_DEPTH + 1 CEs with no pops → the last CE is dropped, log_overflow = 1, irq = 1 and ce_count = LOG_DEPTH + 1. Push and pop together while full → the entry is accepted and log_overflow is not re-set by it.
- Saturation and clear: CNT_W = 4, 17 UEs → ue_count = 4'hF. err_clr asserted together with another UE → counters 0, log empty, log_overflow 0, irq 0.
- Reset mid-operation: rst asserted with rsp_valid = 1 and 2 log entries → all outputs return to their reset values on the next edge.
